// File: rtl/alu_iter_if.sv
// alu_iter request/response bundle.
// master = control unit, slave = ALU.
interface alu_iter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             start_i;
  logic [3:0]       ALU_op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] op2_i;
  logic [CNT_W-1:0] count_i;
  logic             carry_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] res_o;
  logic             carry_o;
  logic             zero_o;
  logic             negative_o;
  logic             overflow_o;
  logic             illegal_o;

  modport master (
    output start_i, ALU_op_i, rs_i,
    output op2_i, count_i, carry_i,
    input  busy_o, done_o, res_o,
    input  carry_o, zero_o, negative_o,
    input  overflow_o, illegal_o
  );

  modport slave (
    input  start_i, ALU_op_i, rs_i,
    input  op2_i, count_i, carry_i,
    output busy_o, done_o, res_o,
    output carry_o, zero_o, negative_o,
    output overflow_o, illegal_o
  );
endinterface

// File: rtl/alu_iter.sv
// Sequential ALU: single-cycle arith/logic,
// iterative one-bit-per-clock shifts.
module alu_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic     clk_i,
  input logic     rst_i,
  alu_iter_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [MSB:0]     work_q;
  logic [CNT_W-1:0] rem_q;

  logic         busy_q;
  logic         done_q;
  logic [MSB:0] res_q;
  logic         carry_q;
  logic         zero_q;
  logic         neg_q;
  logic         ovf_q;
  logic         ill_q;

  logic [MSB:0] a;
  logic [MSB:0] b;
  logic         cin;

  assign a   = bus.rs_i;
  assign b   = bus.op2_i;
  assign cin = bus.carry_i & bus.ALU_op_i[0];

  logic [WIDTH:0] sum;
  logic [MSB:0]   imm_res;
  logic           imm_c;
  logic           imm_v;
  logic           imm_shift;
  logic           imm_ill;

  always_comb begin
    sum       = '0;
    imm_res   = a;
    imm_c     = 1'b0;
    imm_v     = 1'b0;
    imm_shift = 1'b0;
    imm_ill   = 1'b0;
    case (bus.ALU_op_i)
      4'b0000, 4'b0001: begin
        sum = {1'b0, a} + {1'b0, b}
            + {{WIDTH{1'b0}}, cin};
        imm_res = sum[MSB:0];
        imm_c   = sum[WIDTH];
        imm_v   = (a[MSB] == b[MSB])
               && (sum[MSB] != a[MSB]);
      end
      4'b0010, 4'b0011: begin
        sum = {1'b0, a} - {1'b0, b}
            - {{WIDTH{1'b0}}, cin};
        imm_res = sum[MSB:0];
        imm_c   = sum[WIDTH];
        imm_v   = (a[MSB] != b[MSB])
               && (sum[MSB] != a[MSB]);
      end
      4'b0100: imm_res = a & b;
      4'b0101: imm_res = a | b;
      4'b0110: imm_res = a ^ b;
      4'b0111: imm_res = a & ~b;
      4'b1000, 4'b1001, 4'b1010,
      4'b1011, 4'b1100: begin
        // count=0 shift: passthrough, carry_i kept
        imm_shift = 1'b1;
        imm_res   = a;
        imm_c     = bus.carry_i;
      end
      default: imm_ill = 1'b1;
    endcase
  end

  logic [MSB:0] step_res;
  logic         step_out;

  always_comb begin
    step_res = work_q;
    step_out = work_q[0];
    case (op_q)
      4'b1000: begin
        step_res = {work_q[MSB-1:0], 1'b0};
        step_out = work_q[MSB];
      end
      4'b1001: begin
        step_res = {1'b0, work_q[MSB:1]};
        step_out = work_q[0];
      end
      4'b1010: begin
        step_res = {work_q[MSB-1:0], work_q[MSB]};
        step_out = work_q[MSB];
      end
      4'b1011: begin
        step_res = {work_q[0], work_q[MSB:1]};
        step_out = work_q[0];
      end
      default: begin
        step_res = {work_q[MSB], work_q[MSB:1]};
        step_out = work_q[0];
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (imm_ill) begin
              done_q <= 1'b1;
              ill_q  <= 1'b1;
            end else if (imm_shift &&
                         bus.count_i != '0) begin
              op_q    <= bus.ALU_op_i;
              work_q  <= a;
              rem_q   <= bus.count_i;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end else begin
              res_q   <= imm_res;
              carry_q <= imm_c;
              zero_q  <= (imm_res == '0);
              neg_q   <= imm_res[MSB];
              ovf_q   <= imm_v;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (rem_q == CNT_W'(1)) begin
            res_q   <= step_res;
            carry_q <= step_out;
            zero_q  <= (step_res == '0);
            neg_q   <= step_res[MSB];
            ovf_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            work_q <= step_res;
            rem_q  <= rem_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.res_o      = res_q;
  assign bus.carry_o    = carry_q;
  assign bus.zero_o     = zero_q;
  assign bus.negative_o = neg_q;
  assign bus.overflow_o = ovf_q;
  assign bus.illegal_o  = ill_q;
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter with a
// plain-arithmetic reference model.
module tb_alu_iter;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic c;
    logic z;
    logic n;
    logic v;
    logic ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t exp_q[$];
  int   cyc_q[$];

  logic [W-1:0] m_res = '0;
  logic m_c = 1'b0;
  logic m_z = 1'b1;
  logic m_n = 1'b0;
  logic m_v = 1'b0;

  alu_iter_if #(.WIDTH(W)) bus ();

  alu_iter #(.WIDTH(W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [2:0]   cnt,
    input logic         c
  );
    exp_t e;
    int ai, bi, sa, sb, ci, r, sv, n;
    ai = a;
    bi = b;
    sa = $signed(a);
    sb = $signed(b);
    n  = cnt;
    ci = 0;
    r  = 0;
    e  = '0;
    case (op)
      4'd0, 4'd1: begin
        ci = (op == 4'd1) ? int'(c) : 0;
        r  = ai + bi + ci;
        e.c = (r > 255);
        sv = sa + sb + ci;
        e.v = (sv > 127) || (sv < -128);
      end
      4'd2, 4'd3: begin
        ci = (op == 4'd3) ? int'(c) : 0;
        r  = ai - bi - ci;
        e.c = (r < 0);
        sv = sa - sb - ci;
        e.v = (sv > 127) || (sv < -128);
      end
      4'd4: r = ai & bi;
      4'd5: r = ai | bi;
      4'd6: r = ai ^ bi;
      4'd7: r = ai & ~bi;
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
        if (n == 0) begin
          r = ai;
          e.c = c;
        end else begin
          case (op)
            4'd8: begin
              r = ai << n;
              e.c = a[W-n];
            end
            4'd9: begin
              r = ai >> n;
              e.c = a[n-1];
            end
            4'd10: begin
              r = (ai << n) | (ai >> (W - n));
              e.c = a[W-n];
            end
            4'd11: begin
              r = (ai >> n) | (ai << (W - n));
              e.c = a[n-1];
            end
            default: begin
              r = sa >>> n;
              e.c = a[n-1];
            end
          endcase
        end
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.res = m_res;
      e.c   = m_c;
      e.z   = m_z;
      e.n   = m_n;
      e.v   = m_v;
    end else begin
      e.res = r[W-1:0];
      e.z   = (e.res == '0);
      e.n   = e.res[W-1];
    end
    return e;
  endfunction

  task automatic rand_inputs();
    bus.ALU_op_i = 4'($urandom);
    bus.rs_i     = W'($urandom);
    bus.op2_i    = W'($urandom);
    bus.count_i  = 3'($urandom);
    bus.carry_i  = 1'($urandom);
  endtask

  task automatic issue(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [2:0]   cnt,
    input logic         c,
    input bit           hold,
    input bit           push
  );
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (bus.busy_o !== 1'b0 && guard < 64) begin
      bus.start_i = hold;
      rand_inputs();
      guard++;
      @(negedge clk);
    end
    if (guard >= 64) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout busy=%b want 0",
               bus.busy_o);
    end
    bus.start_i  = 1'b1;
    bus.ALU_op_i = op;
    bus.rs_i     = a;
    bus.op2_i    = b;
    bus.count_i  = cnt;
    bus.carry_i  = c;
    if (push) begin
      e = model(op, a, b, cnt, c);
      lat = (op >= 4'd8 && op <= 4'd12) ? int'(cnt) : 0;
      exp_q.push_back(e);
      cyc_q.push_back(cyc + 1 + lat);
      m_res = e.res;
      m_c   = e.c;
      m_z   = e.z;
      m_n   = e.n;
      m_v   = e.v;
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    rand_inputs();
  endtask

  task automatic check_idle(
    input string        name,
    input logic [14:0]  want
  );
    logic [14:0] got;
    got = {bus.busy_o, bus.done_o, bus.res_o,
           bus.carry_o, bus.zero_o, bus.negative_o,
           bus.overflow_o, bus.illegal_o};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    int   ec;
    if (bus.done_o === 1'b1) begin
      tests++;
      got = {bus.res_o, bus.carry_o, bus.zero_o,
             bus.negative_o, bus.overflow_o,
             bus.illegal_o};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done cyc=%0d res=%h",
                 cyc, bus.res_o);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        if (got !== e || cyc != ec ||
            bus.busy_o !== 1'b0) begin
          fails++;
          $display({"FAIL done_check got res=%h c=%b z=%b",
                    " n=%b v=%b ill=%b cyc=%0d busy=%b;",
                    " want res=%h c=%b z=%b n=%b v=%b",
                    " ill=%b cyc=%0d busy=0"},
                   got.res, got.c, got.z, got.n, got.v,
                   got.ill, cyc, bus.busy_o,
                   e.res, e.c, e.z, e.n, e.v, e.ill, ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.start_i = 1'b0;
    rand_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state", 15'b00_00000000_01000);
    rst = 1'b0;

    issue(4'd0, 8'hFF, 8'h01, 3'd0, 1'b0, 0, 1);
    issue(4'd3, 8'h80, 8'h01, 3'd0, 1'b1, 0, 1);
    issue(4'd9, 8'h85, 8'h00, 3'd3, 1'b0, 1, 1);
    issue(4'd8, 8'h85, 8'h00, 3'd3, 1'b0, 1, 1);
    issue(4'd12, 8'h90, 8'h00, 3'd4, 1'b0, 1, 1);
    issue(4'd10, 8'h81, 8'h00, 3'd1, 1'b0, 1, 1);
    issue(4'd5, 8'h50, 8'h0A, 3'd0, 1'b0, 0, 1);
    issue(4'd15, 8'h12, 8'h34, 3'd5, 1'b1, 0, 1);
    issue(4'd8, 8'hA7, 8'h00, 3'd0, 1'b1, 0, 1);
    issue(4'd11, 8'h01, 8'h00, 3'd7, 1'b0, 1, 1);
    issue(4'd1, 8'h7F, 8'h00, 3'd0, 1'b1, 0, 1);

    // reset while a rotate is in flight
    issue(4'd11, 8'h01, 8'h00, 3'd7, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.busy_o !== 1'b1) begin
        fails++;
        $display("FAIL midshift_busy got=%b want 1",
                 bus.busy_o);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_midshift", 15'b00_00000000_01000);
    rst = 1'b0;
    m_res = '0;
    m_c   = 1'b0;
    m_z   = 1'b1;
    m_n   = 1'b0;
    m_v   = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), W'($urandom),
            W'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), bit'($urandom), 1);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want 0",
               exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, sequential successor to the CPU datapath ALU. It performs add/subtract with carry, bitwise logic, and logical/arithmetic/rotate shifts on WIDTH-bit operands. Shifts are iterative, one bit position per clock. Results and flags are registered and framed by a start/busy/done handshake, so the control unit can issue one operation and wait for `done_o`.

## Interface
- `WIDTH`, default 8: operand/result width; must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: width of the shift count.

- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `start_i` input 1: request; accepted only when `busy_o`=0.
- `ALU_op_i` input 4: operation selector, sampled on acceptance.
- `rs_i` input WIDTH: operand A, sampled on acceptance.
- `op2_i` input WIDTH: operand B, sampled on acceptance.
- `count_i` input CNT_W: shift count (0..WIDTH-1), sampled on acceptance.
- `carry_i` input 1: carry/borrow in, sampled on acceptance.
- `busy_o` output 1: shift in progress; new starts are ignored.
- `done_o` output 1: one-cycle pulse; result and flags are valid and updated.
- `res_o` output WIDTH: registered result, held until the next done.
- `carry_o` output 1: registered carry/borrow/shifted-out bit.
- `zero_o` output 1: `res_o`==0.
- `negative_o` output 1: `res_o[WIDTH-1]`.
- `overflow_o` output 1: signed overflow (arithmetic ops only, else 0).
- `illegal_o` output 1: high with `done_o` when the op is undefined.

## Operation
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 ADC: A+B+c.
  - 0010 SUB: A−B.
  - 0011 SBB: A−B−c.
  - 0100 AND.
  - 0101 OR.
  - 0110 XOR.
  - 0111 A & ~B.
  - 1000 SHL: logical left.
  - 1001 SHR: logical right.
  - 1010 ROL.
  - 1011 ROR.
  - 1100 SAR: arithmetic right (MSB replicated).
  - 1101–1111: illegal.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD/ADC: `carry_o` = bit WIDTH of the sum.
  - SUB/SBB: `carry_o` = borrow (1 when A < B+c, unsigned).
  - `overflow_o` = signed overflow of the WIDTH-bit result.
- Logic ops: `carry_o`=0, `overflow_o`=0.
- Shifts: `carry_o` = last bit shifted or rotated out.
  - Left: original A[WIDTH−count].
  - Right: original A[count−1].
  - count=0: `res_o`=A, `carry_o`=`carry_i`.
  - `overflow_o`=0.
- Illegal op: `res_o`, `carry_o`, `zero_o`, `negative_o`, `overflow_o` keep their previous values; `illegal_o`=1 for the done cycle only.
- `zero_o` and `negative_o` always reflect the `res_o` written in the same cycle.
- FSM states:
  - IDLE: `start_i`=1 with a non-shift op, an illegal op, or count=0 → compute, register outputs, pulse `done_o`, stay in IDLE. `start_i` with a shift op and count>0 → load A, count and op into working registers, go to SHIFT.
  - SHIFT: each cycle shifts the working register by one position (fill: 0 for SHL/SHR, wrapped bit for ROL/ROR, MSB for SAR), records the out bit, decrements the remaining count. When the remaining count reaches 1, that cycle's result is written to outputs, `done_o` pulses, and the FSM returns to IDLE.
- `start_i` while `busy_o`=1 is ignored; it is not queued.

## Timing
- Reset values:
  - `busy_o`, `done_o`, `carry_o`, `overflow_o`, `negative_o`, `illegal_o` = 0.
  - `res_o` = 0.
  - `zero_o` = 1.
  - FSM = IDLE.
- Let E0 be the edge at which start is accepted.
- Non-shift, illegal, or count=0: outputs and `done_o` are valid after E0, a latency of 1 cycle.
- Shift with count=n>0: `busy_o` is high after E0 through E(n−1); outputs and `done_o` are valid after E(n), a latency of n cycles.
- `busy_o` falls in the same cycle that `done_o` is high. `start_i` in that cycle is accepted, giving back-to-back operations.
- `done_o` is exactly one cycle wide.
- Input changes after acceptance have no effect on the running operation.
- `rst_i` has priority over everything, including mid-shift:
  - Aborts the operation; no `done_o` is issued.
  - All outputs return to their reset values at that edge.

## Test plan
- ADD, WIDTH=8, A=0xFF, B=0x01, c=0 → one cycle later `res_o`=0x00, `carry_o`=1, `zero_o`=1, `overflow_o`=0, `done_o` one pulse.
- SBB, A=0x80, B=0x01, c=1 → `res_o`=0x7E, `carry_o`=0, `overflow_o`=1, `negative_o`=0.
- SHR, A=0x85, count=3 → `busy_o` high 3 cycles; `start_i` held high throughout is ignored; `done_o` 3 cycles after acceptance; `res_o`=0x10, `carry_o`=1. SHL of the same operands → `res_o`=0x28, `carry_o`=0.
- SAR, A=0x90, count=4 → `res_o`=0xF9, `carry_o`=0, `negative_o`=1. Then back-to-back ROL, A=0x81, count=1, issued in the done cycle → `res_o`=0x03, `carry_o`=1.
- Illegal op 4'b1111 after a prior result 0x5A → `illegal_o`=1 with `done_o`, `res_o` stays 0x5A. Also SHL with count=0 and `carry_i`=1 → `res_o`=A, `carry_o`=1, latency 1.
- Reset mid-shift: ROR with A=0x01, count=7, `rst_i` asserted after 3 busy cycles → next cycle `busy_o`=0, `res_o`=0, `zero_o`=1, and no `done_o` is observed.
